instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with one outstanding request and a small
// in-order queue toward decode; redirects flush the queue and retarget fetch.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      req_pc;
  logic [31:0]      req_pc_next;
  logic             issue;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_data;

  // A request may only go out when the queue can still take its response.
  assign issue     = (state == FETCH) && !redirect && (count < CNT_W'(DEPTH));
  assign imem_req  = issue && rstn;
  assign imem_addr = fetch_pc;
  assign if_valid  = rstn && !empty;
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign pop       = if_valid && if_ready;
  assign push_data = '{pc: req_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    push          = 1'b0;
    case (state)
      FETCH: begin
        if (issue && imem_ready) begin
          state_next    = WAIT;
          req_pc_next   = fetch_pc;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      WAIT: begin
        // A response racing a redirect is dropped and the request is retired.
        if (imem_rvalid) begin
          state_next = FETCH;
          push       = !redirect;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (redirect) fetch_pc_next = redirect_pc & ~32'd3;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory responder plus an occupancy/order model.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  int n_checks;
  int n_fail;
  int n_delivered;
  int cyc;

  // Reference model state
  int          occ;
  bit          outst;
  bit          live;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;

  // Memory responder state
  bit          pending;
  int          timer;
  int          lat;
  bit          rand_ready;
  bit          rand_lat;
  logic [31:0] resp_addr;

  instr_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock: check and update the model mid-cycle, then drive memory.
  task automatic step();
    logic        acc;
    logic        pop;
    logic        rst;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] acc_addr;
    @(negedge clk);
    cyc++;
    rst      = !rstn;
    acc      = rstn && imem_req && imem_ready;
    acc_addr = imem_addr;
    if (rst) begin
      n_checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: imem_req=%b if_valid=%b, required 0/0 (cycle %0d)",
                 imem_req, if_valid, cyc);
      end
      occ = 0; outst = 0; live = 0;
      exp_pc = RESET_PC; exp_fetch = RESET_PC;
    end else begin
      exp_req   = !outst && !redirect && (occ < int'(DEPTH));
      exp_valid = (occ > 0);
      n_checks++;
      if (imem_req !== exp_req) begin
        n_fail++;
        $display("FAIL imem_req: got %b required %b (cycle %0d)", imem_req, exp_req, cyc);
      end
      if (exp_req) begin
        n_checks++;
        if (imem_addr !== exp_fetch) begin
          n_fail++;
          $display("FAIL imem_addr: got %h required %h (cycle %0d)", imem_addr, exp_fetch, cyc);
        end
      end
      n_checks++;
      if (if_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL if_valid: got %b required %b (cycle %0d)", if_valid, exp_valid, cyc);
      end
      pop = exp_valid && if_ready;
      if (pop) begin
        n_checks++;
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h instr=%h required pc=%h instr=%h (cycle %0d)",
                   if_pc, if_instr, exp_pc, mem_word(exp_pc), cyc);
        end
        exp_pc = exp_pc + 32'd4;
        n_delivered++;
      end
      if (redirect) begin
        occ       = 0;
        exp_fetch = redirect_pc & ~32'd3;
        exp_pc    = exp_fetch;
        if (outst && imem_rvalid) outst = 0;
        live = 0;
      end else begin
        if (outst && imem_rvalid) begin
          if (live) occ++;
          outst = 0;
          live  = 0;
        end
        if (pop) occ--;
        if (acc) begin
          outst     = 1;
          live      = 1;
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      pending = 0;
    end else begin
      if (acc) begin
        pending   = 1;
        resp_addr = acc_addr;
        timer     = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end
      if (pending) begin
        timer--;
        if (timer <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(resp_addr);
          pending     = 0;
        end
      end
    end
    imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    rstn     = 1'b0;
    step();
    rstn     = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_request: req=%b addr=%h valid=%b required 1/%h/0",
               imem_req, imem_addr, if_valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int d0;
    lat = 1; rand_lat = 0; rand_ready = 0; if_ready = 1'b1;
    do_reset();
    d0 = n_delivered;
    repeat (20) step();
    n_checks++;
    if (n_delivered - d0 != 9) begin
      n_fail++;
      $display("FAIL stream_rate: delivered %0d in 20 cycles, required 9", n_delivered - d0);
    end
  endtask

  task automatic test_stall();
    int d0;
    lat = 1; rand_lat = 0; rand_ready = 0; if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      if (if_valid === 1'b1) begin
        n_checks++;
        if (if_pc !== RESET_PC || if_instr !== mem_word(RESET_PC)) begin
          n_fail++;
          $display("FAIL stall_hold: pc=%h instr=%h required %h/%h", if_pc, if_instr,
                   RESET_PC, mem_word(RESET_PC));
        end
      end
    end
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_full: req=%b valid=%b required 0/1", imem_req, if_valid);
    end
    if_ready = 1'b1;
    d0 = n_delivered;
    repeat (4) step();
    n_checks++;
    if (n_delivered - d0 != 4) begin
      n_fail++;
      $display("FAIL stall_drain: delivered %0d in 4 cycles, required 4", n_delivered - d0);
    end
    repeat (6) step();
  endtask

  task automatic test_redirect_wait();
    int d0;
    lat = 3; rand_lat = 0; rand_ready = 0; if_ready = 1'b1;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    d0 = n_delivered;
    #2;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_wait_next: valid=%b req=%b required 0/0", if_valid, imem_req);
    end
    repeat (2) step();
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL redir_wait_addr: req=%b addr=%h required 1/00000100", imem_req, imem_addr);
    end
    repeat (6) step();
    n_checks++;
    if (n_delivered - d0 != 1) begin
      n_fail++;
      $display("FAIL redir_wait_count: delivered %0d required 1", n_delivered - d0);
    end
  endtask

  task automatic test_redirect_rvalid();
    int d0;
    lat = 2; rand_lat = 0; rand_ready = 0; if_ready = 1'b1;
    do_reset();
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    d0 = n_delivered;
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_rvalid: req=%b addr=%h valid=%b required 1/00000200/0",
               imem_req, imem_addr, if_valid);
    end
    repeat (5) step();
    n_checks++;
    if (n_delivered - d0 != 1) begin
      n_fail++;
      $display("FAIL redir_rvalid_count: delivered %0d required 1", n_delivered - d0);
    end
  endtask

  task automatic test_wrap();
    lat = 1; rand_lat = 0; rand_ready = 0; if_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    repeat (2) step();
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL pc_wrap: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    lat = 3; rand_lat = 0; rand_ready = 0; if_ready = 1'b1;
    do_reset();
    repeat (3) step();
    step();
    rstn = 1'b0;
    #2;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b valid=%b required 0/0", imem_req, if_valid);
    end
    step();
    rstn = 1'b1;
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_mid_restart: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (8) step();
  endtask

  task automatic test_random();
    int d0;
    rand_lat = 1; rand_ready = 1;
    do_reset();
    d0 = n_delivered;
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0;
    rand_ready = 0;
    if_ready = 1'b1;
    repeat (20) step();
    n_checks++;
    if (n_delivered - d0 < 200) begin
      n_fail++;
      $display("FAIL random_progress: delivered %0d required at least 200", n_delivered - d0);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_delivered = 0; cyc = 0;
    occ = 0; outst = 0; live = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
    pending = 0; timer = 0; lat = 1; rand_ready = 0; rand_lat = 0; resp_addr = '0;
    rstn = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
